// File: rtl/lstm_layr1_ctrl.sv
// Layer-1 LSTM sequencer: walks timesteps t, cells j and elements k, driving the
// datapath's accumulate enables, read addresses and h/c write strobes.
module lstm_layr1_ctrl #(
    parameter int TIMESTEP    = 7,
    parameter int LAYR1_INPUT = 53,
    parameter int LAYR1_CELL  = 53,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  acc_x_1,
    output logic                  acc_h_1,
    output logic [ADDR_WIDTH-1:0] addr_x1,
    output logic [ADDR_WIDTH-1:0] rd_addr_w_1,
    output logic [ADDR_WIDTH-1:0] rd_addr_u_1,
    output logic [ADDR_WIDTH-1:0] rd_addr_b_1,
    output logic [ADDR_WIDTH-1:0] rd_addr_h1,
    output logic [ADDR_WIDTH-1:0] rd_addr_c1,
    output logic                  wr_h1,
    output logic [ADDR_WIDTH-1:0] wr_addr_h1,
    output logic                  wr_c1,
    output logic [ADDR_WIDTH-1:0] wr_addr_c1,
    output logic [2:0]            dbg_state_o
);

    localparam int L  = (LAYR1_INPUT > LAYR1_CELL) ? LAYR1_INPUT : LAYR1_CELL;
    localparam int TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int JW = (LAYR1_CELL > 1) ? $clog2(LAYR1_CELL) : 1;
    localparam int KW = (L > 1) ? $clog2(L) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMESTEP - 1);
    localparam logic [JW-1:0] J_LAST = JW'(LAYR1_CELL - 1);
    localparam logic [KW-1:0] K_LAST = KW'(L - 1);

    localparam logic [31:0] INPUT_U = LAYR1_INPUT;
    localparam logic [31:0] CELL_U  = LAYR1_CELL;
    localparam logic [ADDR_WIDTH-1:0] INPUT_A = ADDR_WIDTH'(LAYR1_INPUT);
    localparam logic [ADDR_WIDTH-1:0] CELL_A  = ADDR_WIDTH'(LAYR1_CELL);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (((TIMESTEP + 1) * LAYR1_CELL > (1 << ADDR_WIDTH)) ||
        (TIMESTEP * LAYR1_INPUT > (1 << ADDR_WIDTH))) begin : g_bad_addr_width
        $error("lstm_layr1_ctrl: ADDR_WIDTH=%0d too narrow for the h/c or x address range", ADDR_WIDTH);
    end

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;

    // Handshake: start is a single-cycle request honoured only in IDLE; busy
    // rises on the accepting edge and falls on the edge leaving DONE.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    t_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_ACC: begin
                if (k_q == K_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_FLUSH: state_d = S_WRITE;
            S_WRITE: begin
                k_d     = '0;
                state_d = S_ACC;
                if (j_q != J_LAST) begin
                    j_d = j_q + JW'(1);
                end else if (t_q != T_LAST) begin
                    j_d = '0;
                    t_d = t_q + TW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    logic                  in_acc, x_lane, h_lane, in_write;
    logic [ADDR_WIDTH-1:0] t_a, j_a, k_a;

    assign in_acc   = (state_d == S_ACC);
    assign in_write = (state_d == S_WRITE);
    assign x_lane   = in_acc && (32'(k_d) < INPUT_U);
    assign h_lane   = in_acc && (32'(k_d) < CELL_U);
    assign t_a      = ADDR_WIDTH'(t_d);
    assign j_a      = ADDR_WIDTH'(j_d);
    assign k_a      = ADDR_WIDTH'(k_d);

    logic                  busy_q, done_q, acc_x_q, acc_h_q, wr_q;
    logic [ADDR_WIDTH-1:0] addr_x_q, addr_w_q, addr_u_q, addr_b_q, addr_h_q, addr_c_q, wr_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_x_q   <= 1'b0;
            acc_h_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_x_q  <= '0;
            addr_w_q  <= '0;
            addr_u_q  <= '0;
            addr_b_q  <= '0;
            addr_h_q  <= '0;
            addr_c_q  <= '0;
            wr_addr_q <= '0;
        end else begin
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            acc_x_q <= x_lane;
            acc_h_q <= h_lane;
            wr_q    <= in_write;
            // Lanes past their vector length keep the last in-range address.
            if (x_lane) begin
                addr_x_q <= t_a * INPUT_A + k_a;
                addr_w_q <= j_a * INPUT_A + k_a;
            end
            if (h_lane) begin
                addr_u_q <= j_a * CELL_A + k_a;
                addr_h_q <= t_a * CELL_A + k_a;
            end
            if (in_acc) begin
                addr_b_q <= j_a;
            end
            if (in_acc && (k_d == '0)) begin
                addr_c_q <= t_a * CELL_A + j_a;
            end
            if (in_write) begin
                wr_addr_q <= (t_a + ONE_A) * CELL_A + j_a;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign acc_x_1     = acc_x_q;
    assign acc_h_1     = acc_h_q;
    assign addr_x1     = addr_x_q;
    assign rd_addr_w_1 = addr_w_q;
    assign rd_addr_u_1 = addr_u_q;
    assign rd_addr_b_1 = addr_b_q;
    assign rd_addr_h1  = addr_h_q;
    assign rd_addr_c1  = addr_c_q;
    assign wr_h1       = wr_q;
    assign wr_c1       = wr_q;
    assign wr_addr_h1  = wr_addr_q;
    assign wr_addr_c1  = wr_addr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lstm_layr1_ctrl.sv
// Directed bench for lstm_layr1_ctrl: small, unequal-size and default-size instances.
module tb_lstm_layr1_ctrl;

    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_start = 1'b0, u_start = 1'b0, d_start = 1'b0;

    logic s_busy, s_done, s_accx, s_acch, s_wrh, s_wrc;
    logic [AW-1:0] s_ax, s_aw, s_au, s_ab, s_ah, s_ac, s_wah, s_wac;
    logic [2:0] s_st;
    logic u_busy, u_done, u_accx, u_acch, u_wrh, u_wrc;
    logic [AW-1:0] u_ax, u_aw, u_au, u_ab, u_ah, u_ac, u_wah, u_wac;
    logic [2:0] u_st;
    logic d_busy, d_done, d_accx, d_acch, d_wrh, d_wrc;
    logic [AW-1:0] d_ax, d_aw, d_au, d_ab, d_ah, d_ac, d_wah, d_wac;
    logic [2:0] d_st;

    always #5 clk = ~clk;

    lstm_layr1_ctrl #(.TIMESTEP(2), .LAYR1_INPUT(3), .LAYR1_CELL(3), .ADDR_WIDTH(AW)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .acc_x_1(s_accx), .acc_h_1(s_acch), .addr_x1(s_ax), .rd_addr_w_1(s_aw),
        .rd_addr_u_1(s_au), .rd_addr_b_1(s_ab), .rd_addr_h1(s_ah), .rd_addr_c1(s_ac),
        .wr_h1(s_wrh), .wr_addr_h1(s_wah), .wr_c1(s_wrc), .wr_addr_c1(s_wac), .dbg_state_o(s_st));

    lstm_layr1_ctrl #(.TIMESTEP(1), .LAYR1_INPUT(4), .LAYR1_CELL(2), .ADDR_WIDTH(AW)) u_uneq (
        .clk(clk), .rst(rst), .start(u_start), .busy(u_busy), .done(u_done),
        .acc_x_1(u_accx), .acc_h_1(u_acch), .addr_x1(u_ax), .rd_addr_w_1(u_aw),
        .rd_addr_u_1(u_au), .rd_addr_b_1(u_ab), .rd_addr_h1(u_ah), .rd_addr_c1(u_ac),
        .wr_h1(u_wrh), .wr_addr_h1(u_wah), .wr_c1(u_wrc), .wr_addr_c1(u_wac), .dbg_state_o(u_st));

    lstm_layr1_ctrl #(.TIMESTEP(7), .LAYR1_INPUT(53), .LAYR1_CELL(53), .ADDR_WIDTH(AW)) u_dflt (
        .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
        .acc_x_1(d_accx), .acc_h_1(d_acch), .addr_x1(d_ax), .rd_addr_w_1(d_aw),
        .rd_addr_u_1(d_au), .rd_addr_b_1(d_ab), .rd_addr_h1(d_ah), .rd_addr_c1(d_ac),
        .wr_h1(d_wrh), .wr_addr_h1(d_wah), .wr_c1(d_wrc), .wr_addr_c1(d_wac), .dbg_state_o(d_st));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Statistics gathered by run_small for one start of the small instance.
    int s_accx_cnt, s_done_cnt, s_done_cyc, s_overlap, s_wc_diff;
    logic s_busy1, s_busy35;
    logic [AW-1:0] wr_got[$];
    logic [AW-1:0] rdc_got[$];
    logic [AW-1:0] tr_w[3], tr_u[3], tr_x[3], tr_h[3], tr_b[3];

    // start is raised in cycle 0; observation cycle n follows the n-th edge after that.
    task automatic run_small(input bit poke);
        s_accx_cnt = 0; s_done_cnt = 0; s_done_cyc = -1; s_overlap = 0; s_wc_diff = 0;
        s_busy1 = 1'b0; s_busy35 = 1'b1;
        wr_got.delete();
        rdc_got.delete();
        s_start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (s_accx) s_accx_cnt++;
            if (s_wrh) wr_got.push_back(s_wah);
            if (s_wrc) rdc_got.push_back(s_ac);
            if ((s_wrh || s_wrc) && (s_accx || s_acch)) s_overlap++;
            if ((s_wrh !== s_wrc) || (s_wah !== s_wac)) s_wc_diff++;
            if (s_done) begin
                s_done_cnt++;
                if (s_done_cyc < 0) s_done_cyc = cyc;
            end
            if (cyc == 1) s_busy1 = s_busy;
            if (cyc == 35) s_busy35 = s_busy;
            if (cyc >= 21 && cyc <= 23) begin
                tr_w[cyc-21] = s_aw; tr_u[cyc-21] = s_au; tr_x[cyc-21] = s_ax;
                tr_h[cyc-21] = s_ah; tr_b[cyc-21] = s_ab;
            end
            s_start = poke && (cyc == 10 || cyc == 31);
        end
        s_start = 1'b0;
    endtask

    logic [AW-1:0] exp_q[$];
    logic [5:0] accx_pat, acch_pat;
    int cnt_a, cnt_b, cnt_c, done_cyc;
    logic [AW-1:0] last_wr, u_au3, u_ah4;

    initial begin
        // Reset held three cycles with start pulsing.
        rst = 1'b0;
        s_start = 1'b1; u_start = 1'b1; d_start = 1'b1;
        repeat (3) tick();
        check("rst_small_outputs_zero", 32'(|{s_busy, s_done, s_accx, s_acch, s_wrh, s_wrc,
              s_ax, s_aw, s_au, s_ab, s_ah, s_ac, s_wah, s_wac}), 0);
        check("rst_uneq_outputs_zero", 32'(|{u_busy, u_done, u_accx, u_acch, u_wrh, u_wrc,
              u_ax, u_aw, u_au, u_ab, u_ah, u_ac, u_wah, u_wac}), 0);
        check("rst_dflt_busy", 32'(d_busy), 0);
        s_start = 1'b0; u_start = 1'b0; d_start = 1'b0;
        tick();
        rst = 1'b1;
        cnt_a = 0;
        repeat (5) begin
            tick();
            if (s_busy || s_accx || s_wrh || u_busy || d_busy) cnt_a++;
        end
        check("post_rst_no_activity", cnt_a, 0);

        // Small run with start re-pulsed mid-run and during DONE.
        run_small(1'b1);
        check("small_busy_cycle1", 32'(s_busy1), 1);
        check("small_accx_cycles", s_accx_cnt, 18);
        check("small_done_cycle", s_done_cyc, 31);
        check("small_done_pulses", s_done_cnt, 1);
        check("small_wr_acc_overlap", s_overlap, 0);
        check("small_h_c_strobes_match", s_wc_diff, 0);
        check("small_ignored_start_busy", 32'(s_busy35), 0);
        exp_q = '{12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8};
        check("small_wr_count", wr_got.size(), 6);
        foreach (exp_q[i]) if (i < wr_got.size()) check("small_wr_addr_h", wr_got[i], exp_q[i]);
        exp_q = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5};
        check("small_rdc_count", rdc_got.size(), 6);
        foreach (exp_q[i]) if (i < rdc_got.size()) check("small_rd_addr_c", rdc_got[i], exp_q[i]);
        exp_q = '{12'd3, 12'd4, 12'd5};
        foreach (exp_q[i]) begin
            check("trace_w", tr_w[i], exp_q[i]);
            check("trace_u", tr_u[i], exp_q[i]);
            check("trace_x", tr_x[i], exp_q[i]);
            check("trace_h", tr_h[i], exp_q[i]);
            check("trace_b", tr_b[i], 1);
        end

        // Restart from t=j=0, then abort during the WRITE of cell 2.
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("restart_busy", 32'(s_busy), 1);
        check("restart_addr_x", s_ax, 0);
        check("restart_rd_addr_c", s_ac, 0);
        check("restart_rd_addr_b", s_ab, 0);
        repeat (14) tick();
        check("abort_in_write_strobe", 32'(s_wrh), 1);
        check("abort_in_write_addr", s_wah, 5);
        #2 rst = 1'b0;
        #1;
        check("abort_wr_h_async", 32'(s_wrh), 0);
        check("abort_busy_async", 32'(s_busy), 0);
        repeat (2) tick();
        rst = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (40) begin
            tick();
            if (s_done) cnt_a++;
            if (s_wrh || s_busy) cnt_b++;
        end
        check("abort_no_done", cnt_a, 0);
        check("abort_no_activity", cnt_b, 0);

        run_small(1'b0);
        check("fresh_done_cycle", s_done_cyc, 31);
        check("fresh_done_pulses", s_done_cnt, 1);
        check("fresh_wr_count", wr_got.size(), 6);
        if (wr_got.size() > 0) check("fresh_first_wr", wr_got[0], 3);

        // Unequal sizes: INPUT=4, CELL=2, TIMESTEP=1.
        u_start = 1'b1;
        accx_pat = '0; acch_pat = '0; cnt_a = 0; cnt_b = 0; done_cyc = -1;
        u_au3 = '0; u_ah4 = '0;
        wr_got.delete();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            u_start = 1'b0;
            if (cyc <= 6) begin
                accx_pat = {accx_pat[4:0], u_accx};
                acch_pat = {acch_pat[4:0], u_acch};
            end
            if (u_accx) cnt_a++;
            if (u_acch) cnt_b++;
            if (u_wrh) wr_got.push_back(u_wah);
            if (u_done && done_cyc < 0) done_cyc = cyc;
            if (cyc == 3) u_au3 = u_au;
            if (cyc == 4) u_ah4 = u_ah;
        end
        check("uneq_accx_pattern", 32'(accx_pat), 32'(6'b111100));
        check("uneq_acch_pattern", 32'(acch_pat), 32'(6'b110000));
        check("uneq_accx_total", cnt_a, 8);
        check("uneq_acch_total", cnt_b, 4);
        check("uneq_u_hold", u_au3, 1);
        check("uneq_h_hold", u_ah4, 1);
        check("uneq_done_cycle", done_cyc, 13);
        check("uneq_wr_count", wr_got.size(), 2);
        exp_q = '{12'd2, 12'd3};
        foreach (exp_q[i]) if (i < wr_got.size()) check("uneq_wr_addr", wr_got[i], exp_q[i]);

        // Default parameters, full run with a bounded wait.
        d_start = 1'b1;
        done_cyc = -1; cnt_c = 0; last_wr = '0;
        for (int cyc = 1; cyc <= 21000; cyc++) begin
            tick();
            d_start = 1'b0;
            if (d_wrh) begin
                cnt_c++;
                last_wr = d_wah;
            end
            if (d_done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("dflt_done_cycle", done_cyc, 20406);
        check("dflt_last_wr_addr", last_wr, 423);
        check("dflt_wr_count", cnt_c, 371);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
